// File: rtl/dmem_pkg.sv
// Shared types and widths for the dmem load/store front end.
package dmem_pkg;

  localparam int SDATA_W   = 16;
  localparam int VDATA_W   = 256;
  localparam int ADDR_W    = 32;
  localparam int DAU_TAG_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } dau_state_t;

  // Load context carried from accept to the response.
  typedef struct packed {
    logic                 vec;
    logic [DAU_TAG_W-1:0] tag;
    logic                 oor;
  } dau_req_t;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational range check of a word address against the scalar or vector space.
module dmem_addr_check
  import dmem_pkg::*;
#(
  parameter int SADDR_W = 18,
  parameter int VADDR_W = 14
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_vec,
  output logic              o_oor
);

  logic [ADDR_W-1:0] w_hi_s;
  logic [ADDR_W-1:0] w_hi_v;

  // Any bit above the selected space's width is out of range.
  assign w_hi_s = i_addr >> SADDR_W;
  assign w_hi_v = i_addr >> VADDR_W;
  assign o_oor  = i_vec ? (w_hi_v != '0) : (w_hi_s != '0);

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store front end to dmem: stores write in the accept cycle, loads respond 2 cycles after accept.
// Request side stalls while a load is in flight; a retiring response may overlap a new request.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int SADDR_W = 18,
  parameter int VADDR_W = 14,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic               req_vec,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [SDATA_W-1:0] req_wdata_s,
  input  logic [VDATA_W-1:0] req_wdata_v,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_vec,
  output logic [SDATA_W-1:0] rsp_data_s,
  output logic [VDATA_W-1:0] rsp_data_v,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err,
  output logic               st_err,
  output logic               mem_w_enable,
  output logic               mem_src_sel,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [SDATA_W-1:0] mem_w_data_a,
  output logic [VDATA_W-1:0] mem_w_data_b,
  input  logic [SDATA_W-1:0] mem_q_a,
  input  logic [VDATA_W-1:0] mem_q_b
);

  dau_state_t         r_state;
  dau_state_t         w_state_nxt;
  dau_req_t           r_req;
  logic               w_oor;
  logic               w_req_ready;
  logic               w_acc;
  logic               w_ld_acc;
  logic               w_st_acc;
  logic               r_st_err;
  logic               r_rsp_vec;
  logic               r_rsp_err;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [SDATA_W-1:0] r_rsp_data_s;
  logic [VDATA_W-1:0] r_rsp_data_v;

  dmem_addr_check #(
    .SADDR_W (SADDR_W),
    .VADDR_W (VADDR_W)
  ) u_addr_check (
    .i_addr (req_addr),
    .i_vec  (req_vec),
    .o_oor  (w_oor)
  );

  // In RSP the request side opens exactly when the response retires.
  assign w_req_ready = (r_state == IDLE) | ((r_state == RSP) & rsp_ready);
  assign w_acc       = req_valid & w_req_ready;
  assign w_ld_acc    = w_acc & ~req_we;
  assign w_st_acc    = w_acc & req_we;

  assign mem_addr     = req_addr;
  assign mem_src_sel  = req_vec;
  assign mem_w_data_a = req_wdata_s;
  assign mem_w_data_b = req_wdata_v;
  // Gated by rst so a request pending across reset never reaches the array.
  assign mem_w_enable = w_st_acc & ~w_oor & ~rst;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_ld_acc) w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        w_state_nxt = RSP;
      end
      RSP: begin
        if (rsp_ready) w_state_nxt = w_ld_acc ? RD_WAIT : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req <= '0;
    end else if (w_ld_acc) begin
      r_req <= '{vec: req_vec, tag: DAU_TAG_W'(req_tag), oor: w_oor};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_err <= 1'b0;
    end else begin
      r_st_err <= w_st_acc & w_oor;
    end
  end

  // dmem read data is valid in RD_WAIT; the unselected field is forced to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_vec    <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_tag    <= '0;
      r_rsp_data_s <= '0;
      r_rsp_data_v <= '0;
    end else if (r_state == RD_WAIT) begin
      r_rsp_vec    <= r_req.vec;
      r_rsp_err    <= r_req.oor;
      r_rsp_tag    <= TAG_W'(r_req.tag);
      r_rsp_data_s <= (r_req.oor | r_req.vec)  ? '0 : mem_q_a;
      r_rsp_data_v <= (r_req.oor | ~r_req.vec) ? '0 : mem_q_b;
    end
  end

  assign req_ready  = w_req_ready;
  assign rsp_valid  = (r_state == RSP);
  assign rsp_vec    = r_rsp_vec;
  assign rsp_err    = r_rsp_err;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_data_s = r_rsp_data_s;
  assign rsp_data_v = r_rsp_data_v;
  assign st_err     = r_st_err;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed and random bench for dmem_access_unit with a behavioural dmem and a load scoreboard.
module tb_dmem_access_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_we, req_vec;
  logic [31:0]  req_addr;
  logic [15:0]  req_wdata_s;
  logic [255:0] req_wdata_v;
  logic [4:0]   req_tag;
  logic         rsp_valid, rsp_ready, rsp_vec, rsp_err, st_err;
  logic [15:0]  rsp_data_s;
  logic [255:0] rsp_data_v;
  logic [4:0]   rsp_tag;
  logic         mem_w_enable, mem_src_sel;
  logic [31:0]  mem_addr;
  logic [15:0]  mem_w_data_a, mem_q_a;
  logic [255:0] mem_w_data_b, mem_q_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.SADDR_W(18), .VADDR_W(14), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_vec(req_vec),
    .req_addr(req_addr), .req_wdata_s(req_wdata_s), .req_wdata_v(req_wdata_v), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vec(rsp_vec), .rsp_data_s(rsp_data_s),
    .rsp_data_v(rsp_data_v), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .st_err(st_err),
    .mem_w_enable(mem_w_enable), .mem_src_sel(mem_src_sel), .mem_addr(mem_addr),
    .mem_w_data_a(mem_w_data_a), .mem_w_data_b(mem_w_data_b), .mem_q_a(mem_q_a), .mem_q_b(mem_q_b)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural dmem: synchronous read, write on w_enable.
  bit [15:0]   dm_a [int unsigned];
  bit [255:0]  dm_b [int unsigned];
  int unsigned ka, kb;
  always @(posedge clk) begin
    ka = 32'(mem_addr[17:0]);
    kb = 32'(mem_addr[13:0]);
    mem_q_a <= dm_a.exists(ka) ? dm_a[ka] : 16'h0;
    mem_q_b <= dm_b.exists(kb) ? dm_b[kb] : 256'h0;
    if (mem_w_enable) begin
      if (mem_src_sel) dm_b[kb] = mem_w_data_b;
      else             dm_a[ka] = mem_w_data_a;
    end
  end

  // Scoreboard: reference memory updated at accept, expected loads queued in order.
  typedef struct {
    logic         vec;
    logic [4:0]   tag;
    logic         err;
    logic [15:0]  ds;
    logic [255:0] dv;
  } exp_t;

  exp_t        q[$];
  bit [15:0]   ref_a [bit [31:0]];
  bit [255:0]  ref_b [bit [31:0]];
  logic        prev_hold = 1'b0;
  logic        exp_st_err = 1'b0;
  logic [255:0] prev_v;
  logic [22:0] prev_misc;

  always @(negedge clk) begin : mon
    logic acc, moor;
    exp_t e;
    acc  = req_valid & req_ready;
    moor = req_vec ? (req_addr[31:14] != 0) : (req_addr[31:18] != 0);
    chk("mem_we", mem_w_enable, !rst && acc && req_we && !moor);
    chk("st_err", st_err, rst ? 1'b0 : exp_st_err);
    if (rst) begin
      q.delete();
      exp_st_err = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      exp_st_err = acc & req_we & moor;
      if (prev_hold) begin
        chk("hold_vld", rsp_valid, 1);
        chk("hold_v", rsp_data_v, prev_v);
        chk("hold_misc", {rsp_vec, rsp_tag, rsp_err, rsp_data_s}, prev_misc);
      end
      if (rsp_valid) chk("rdy_follow", req_ready, rsp_ready);
      if (acc && req_we && !moor) begin
        if (req_vec) ref_b[req_addr] = req_wdata_v;
        else         ref_a[req_addr] = req_wdata_s;
      end
      if (acc && !req_we) begin
        e.vec = req_vec;
        e.tag = req_tag;
        e.err = moor;
        e.ds  = (moor || req_vec)  ? 16'h0  : (ref_a.exists(req_addr) ? ref_a[req_addr] : 16'h0);
        e.dv  = (moor || !req_vec) ? 256'h0 : (ref_b.exists(req_addr) ? ref_b[req_addr] : 256'h0);
        q.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_extra", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_vec", rsp_vec, e.vec);
          chk("sb_tag", rsp_tag, e.tag);
          chk("sb_err", rsp_err, e.err);
          chk("sb_ds", rsp_data_s, e.ds);
          chk("sb_dv", rsp_data_v, e.dv);
        end
      end
      prev_hold = rsp_valid & !rsp_ready;
      prev_v    = rsp_data_v;
      prev_misc = {rsp_vec, rsp_tag, rsp_err, rsp_data_s};
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic we, input logic vec, input logic [31:0] addr,
                      input logic [15:0] ws, input logic [255:0] wv, input logic [4:0] tag);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_vec = vec; req_addr = addr;
    req_wdata_s = ws; req_wdata_v = wv; req_tag = tag;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  // Counts cycles from the cycle after acceptance; leaves the bench at the negedge with rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    int lat, sent, cyc, r, n;
    logic acc_now;
    logic [255:0] pat, npat;

    rst = 1'b1; req_valid = 0; req_we = 0; req_vec = 0; req_addr = 0;
    req_wdata_s = 0; req_wdata_v = 0; req_tag = 0; rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(i);
    npat = ~pat;

    repeat (2) @(posedge clk); #1;
    chk("rst_rdy", req_ready, 1);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_sterr", st_err, 0);
    chk("rst_dv", rsp_data_v, 0);
    chk("rst_misc", {rsp_data_s, rsp_tag, rsp_vec}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Scalar round trip
    send(1, 0, 32'h10, 16'hBEEF, 256'h0, 5'd0);
    chk("st_noerr", st_err, 0);
    send(0, 0, 32'h10, 16'h0, 256'h0, 5'd7);
    wait_rsp(lat);
    chk("s_lat", lat, 2);
    chk("s_data", rsp_data_s, 16'hBEEF);
    chk("s_vec", rsp_vec, 0);
    chk("s_tag", rsp_tag, 5'd7);
    chk("s_err", rsp_err, 0);
    chk("s_dv", rsp_data_v, 0);
    @(posedge clk); #1;

    // Vector round trip
    send(1, 1, 32'h3, 16'h0, pat, 5'd0);
    send(0, 1, 32'h3, 16'h0, 256'h0, 5'd3);
    wait_rsp(lat);
    chk("v_lat", lat, 2);
    chk("v_data", rsp_data_v, pat);
    chk("v_ds", rsp_data_s, 0);
    chk("v_vec", rsp_vec, 1);
    chk("v_tag", rsp_tag, 5'd3);
    @(posedge clk); #1;

    // Out-of-range scalar store must not write and must pulse st_err once
    req_valid = 1; req_we = 1; req_vec = 0; req_addr = 32'h40000; req_wdata_s = 16'h5555;
    @(negedge clk);
    chk("oor_we", mem_w_enable, 0);
    chk("oor_rdy", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0; req_we = 0;
    chk("oor_sterr", st_err, 1);
    @(posedge clk); #1;
    chk("oor_sterr_end", st_err, 0);
    send(0, 0, 32'h0, 16'h0, 256'h0, 5'd1);
    wait_rsp(lat);
    chk("oor_noalias", rsp_data_s, 16'h0);
    @(posedge clk); #1;

    // Out-of-range vector load returns error with zeroed data
    send(1, 1, 32'h0, 16'h0, npat, 5'd0);
    send(0, 1, 32'h4000, 16'h0, 256'h0, 5'd9);
    wait_rsp(lat);
    chk("voor_err", rsp_err, 1);
    chk("voor_dv", rsp_data_v, 0);
    chk("voor_ds", rsp_data_s, 0);
    chk("voor_tag", rsp_tag, 5'd9);
    @(posedge clk); #1;

    // Back-pressure: response held, then overlapped with a new load
    rsp_ready = 0;
    send(0, 0, 32'h10, 16'h0, 256'h0, 5'd4);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", rsp_valid, 1);
      chk("bp_rdy", req_ready, 0);
      chk("bp_data", {rsp_tag, rsp_data_s}, {5'd4, 16'hBEEF});
    end
    @(posedge clk); #1;
    rsp_ready = 1; req_valid = 1; req_we = 0; req_vec = 1; req_addr = 32'h3; req_tag = 5'd6;
    @(negedge clk);
    chk("bp_acc", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    wait_rsp(lat);
    chk("bp_lat", lat, 2);
    chk("bp_dv", rsp_data_v, pat);
    chk("bp_tag", rsp_tag, 5'd6);
    @(posedge clk); #1;

    // Async reset in RD_WAIT drops the response; a pending store must not write
    send(0, 0, 32'h10, 16'h0, 256'h0, 5'd2);
    req_valid = 1; req_we = 1; req_vec = 0; req_addr = 32'h10; req_wdata_s = 16'h1234;
    #2 rst = 1'b1;
    #1;
    chk("mr_vld", rsp_valid, 0);
    chk("mr_rdy", req_ready, 1);
    chk("mr_we", mem_w_enable, 0);
    @(posedge clk); #1;
    req_valid = 0; req_we = 0; rst = 1'b0;
    chk("mr_vld2", rsp_valid, 0);
    send(0, 0, 32'h10, 16'h0, 256'h0, 5'd8);
    wait_rsp(lat);
    chk("mr_keep", rsp_data_s, 16'hBEEF);
    chk("mr_tag", rsp_tag, 5'd8);
    @(posedge clk); #1;

    // Random mix checked by the scoreboard
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      if (!req_valid && $urandom_range(0, 3) != 0) begin
        req_valid = 1;
        req_we  = 1'($urandom_range(0, 1));
        req_vec = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 9);
        if (req_vec) req_addr = (r == 0) ? 32'h4000 + $urandom_range(0, 3) : $urandom_range(0, 7);
        else         req_addr = (r == 0) ? 32'h40000 | $urandom_range(0, 15) : $urandom_range(0, 15);
        if (r == 1) req_addr = 32'h8000_0000;
        req_tag = 5'($urandom);
        req_wdata_s = 16'($urandom);
        for (int i = 0; i < 8; i++) req_wdata_v[i*32 +: 32] = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_now = req_valid & req_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        req_valid = 0;
        sent++;
      end
      cyc++;
    end
    chk("rand_sent", sent, 1000);
    req_valid = 0;
    rsp_ready = 1;
    for (n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
    chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
